// File: rtl/run_cycle_monitor.sv
// run_cycle_monitor: arms on Arm, counts cycles/retires from Start until Halt, Abort or watchdog, holds results until Ack.
// Ports: CLK, Reset_n (async active-low); Arm, Start, Retire, Halt, Abort, Ack strobes;
//        CycleCount, InstrCount, Busy, Done, TimedOut, Overflow registered outputs.
// Macro RUN_STALL_COUNT_EN adds StallCount (RUN cycles without a retire).
module run_cycle_monitor #(
  parameter int WIDTH = 16,
  parameter int unsigned TIMEOUT = 16'hFFF0
) (
  input  logic             CLK,
  input  logic             Reset_n,
  input  logic             Arm,
  input  logic             Start,
  input  logic             Retire,
  input  logic             Halt,
  input  logic             Abort,
  input  logic             Ack,
  output logic [WIDTH-1:0] CycleCount,
  output logic [WIDTH-1:0] InstrCount,
  output logic             Busy,
  output logic             Done,
  output logic             TimedOut,
  output logic             Overflow
`ifdef RUN_STALL_COUNT_EN
  ,
  output logic [WIDTH-1:0] StallCount
`endif
);
  localparam logic [1:0] IDLE = 2'd0, ARMED = 2'd1, RUN = 2'd2, DONE = 2'd3;
  logic [1:0] state, nstate;
  logic [WIDTH-1:0] ncyc, ninst;
  logic nto, nov;
`ifdef RUN_STALL_COUNT_EN
  logic [WIDTH-1:0] nstall;
`endif
  always_comb begin
    nstate = state;
    ncyc = CycleCount;
    ninst = InstrCount;
    nto = TimedOut;
    nov = Overflow;
`ifdef RUN_STALL_COUNT_EN
    nstall = StallCount;
`endif
    if (state == IDLE || state == DONE) begin
      if (Arm) begin
        nstate = ARMED;
        ncyc = '0;
        ninst = '0;
        nto = 1'b0;
        nov = 1'b0;
`ifdef RUN_STALL_COUNT_EN
        nstall = '0;
`endif
      end else if (state == DONE && Ack) nstate = IDLE;
    end else if (state == ARMED) begin
      if (Abort) nstate = IDLE;
      else if (Start) begin
        nstate = RUN;
        ncyc = WIDTH'(1);
        ninst = WIDTH'(Retire);
`ifdef RUN_STALL_COUNT_EN
        nstall = WIDTH'(!Retire);
`endif
      end else if (Arm) begin
        ncyc = '0;
        ninst = '0;
`ifdef RUN_STALL_COUNT_EN
        nstall = '0;
`endif
      end
    end else if (Abort) nstate = IDLE;
    else begin
      // saturating increments; Overflow latches on the edge a count reaches all-ones
      ncyc = &CycleCount ? CycleCount : CycleCount + WIDTH'(1);
      ninst = (Retire && !(&InstrCount)) ? InstrCount + WIDTH'(1) : InstrCount;
      nov = Overflow | (&ncyc) | (&ninst);
`ifdef RUN_STALL_COUNT_EN
      nstall = (!Retire && !(&StallCount)) ? StallCount + WIDTH'(1) : StallCount;
      nov = nov | (&nstall);
`endif
      if (Halt) nstate = DONE;
      else if (TIMEOUT != 0 && 32'(ncyc) == TIMEOUT) begin
        nstate = DONE;
        nto = 1'b1;
      end
    end
  end
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
      CycleCount <= '0;
      InstrCount <= '0;
      Busy <= 1'b0;
      Done <= 1'b0;
      TimedOut <= 1'b0;
      Overflow <= 1'b0;
`ifdef RUN_STALL_COUNT_EN
      StallCount <= '0;
`endif
    end else begin
      state <= nstate;
      CycleCount <= ncyc;
      InstrCount <= ninst;
      Busy <= nstate == ARMED || nstate == RUN;
      Done <= nstate == DONE;
      TimedOut <= nto;
      Overflow <= nov;
`ifdef RUN_STALL_COUNT_EN
      StallCount <= nstall;
`endif
    end
  end
endmodule
